// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: bus widths, reset level,
// stall-vector encodings and FSM state encodings.
// No logic and no latency; every hazard_ctrl file imports this package.
package hazard_ctrl_pkg;

    // Reset level: reset is active-high.
    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;

    // Width of a register-file address and of a register-file data word.
    localparam int RegAddrBus = 5;
    localparam int RegBus     = 32;

    // Stall-vector width and bit positions (bit0 pc ... bit5 wb).
    localparam int StallW   = 6;
    localparam int StallPc  = 0;
    localparam int StallIf  = 1;
    localparam int StallId  = 2;
    localparam int StallEx  = 3;
    localparam int StallMem = 4;
    localparam int StallWb  = 5;

    // Stall encodings.
    // StallNone  : everything flows.
    // StallHzd   : freeze pc/if/id while a RAW or WAW hazard resolves; EX
    //              and later keep draining so the producer reaches WB.
    // StallMc    : also freeze EX while a multi-cycle op occupies it.
    localparam logic [StallW-1:0] StallNone = 6'b000000;
    localparam logic [StallW-1:0] StallHzd  = 6'b000111;
    localparam logic [StallW-1:0] StallMc   = 6'b001111;

    // Stall-cycle counter width and its saturation value.
    localparam int                 StallCntW   = 16;
    localparam logic [StallCntW-1:0] StallCntMax = 16'hFFFF;

    // Multi-cycle counter width; wide enough for the largest legal latency (15).
    localparam int McCntW = 4;

    // Controller FSM states.
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } hz_state_e;

    // One-hot decode of a register address with r0 forced to zero.
    function automatic logic [RegBus-1:0] reg_onehot(input logic                  en,
                                                     input logic [RegAddrBus-1:0] addr);
        logic [RegBus-1:0] m;
        m = '0;
        if (en && (addr != '0)) begin
            m[addr] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: one pending bit per register, set on issue, cleared on WB.
// Lookups are combinational (0 cycles); updates take effect on the next edge.
// No backpressure: set/clear are applied every cycle they are presented.
module hazard_scoreboard
    import hazard_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  set_en_i,
    input  logic [RegAddrBus-1:0] set_addr_i,
    input  logic                  clr_en_i,
    input  logic [RegAddrBus-1:0] clr_addr_i,
    input  logic [RegAddrBus-1:0] rd1_addr_i,
    input  logic [RegAddrBus-1:0] rd2_addr_i,
    input  logic [RegAddrBus-1:0] wd_addr_i,
    output logic                  rd1_hit_o,
    output logic                  rd2_hit_o,
    output logic                  wd_hit_o,
    output logic [RegBus-1:0]     pending_o
);

    logic [RegBus-1:0] pending_q;
    logic [RegBus-1:0] pending_d;
    logic [RegBus-1:0] set_mask;
    logic [RegBus-1:0] clr_mask;
    logic [RegBus-1:0] visible;

    // Masks, same-cycle WB bypass view, and next scoreboard value.
    always_comb begin
        set_mask = reg_onehot(set_en_i, set_addr_i);
        clr_mask = reg_onehot(clr_en_i, clr_addr_i);
        // A register being written back this cycle is already readable via
        // regfile write-through, so it no longer counts as outstanding.
        visible  = pending_q & ~clr_mask;
        // Set is applied after clear so a same-edge set/clear leaves it set.
        pending_d    = visible | set_mask;
        pending_d[0] = 1'b0;
        rd1_hit_o = visible[rd1_addr_i];
        rd2_hit_o = visible[rd2_addr_i];
        wd_hit_o  = visible[wd_addr_i];
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: RAW/WAW interlock plus multi-cycle EX occupancy.
// Stall/issue are combinational from this cycle's ID/WB inputs and current state.
// Stalls pc/if/id on a hazard, additionally ex while a multi-cycle op is busy.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    // Cycles a multi-cycle op occupies EX; legal range 2..15.
    parameter int MC_LAT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid_i,
    input  logic                  id_reg1_read_i,
    input  logic                  id_reg2_read_i,
    input  logic [RegAddrBus-1:0] id_reg1_addr_i,
    input  logic [RegAddrBus-1:0] id_reg2_addr_i,
    input  logic                  id_wreg_i,
    input  logic [RegAddrBus-1:0] id_wd_i,
    input  logic                  id_mc_i,
    input  logic                  wb_wreg_i,
    input  logic [RegAddrBus-1:0] wb_wd_i,
    input  logic                  flush_i,
    output logic [StallW-1:0]     stall_o,
    output logic                  issue_o,
    output logic                  busy_o,
    output logic [RegBus-1:0]     pending_o,
    output logic [StallCntW-1:0]  stall_cnt_o
);

    localparam logic [McCntW-1:0] McLoad = McCntW'(MC_LAT - 1);

    hz_state_e            state_q;
    hz_state_e            state_d;
    logic [McCntW-1:0]    cnt_q;
    logic [McCntW-1:0]    cnt_d;
    logic [StallCntW-1:0] stall_cnt_q;
    logic [StallCntW-1:0] stall_cnt_d;

    logic in_reset;
    logic rd1_hit;
    logic rd2_hit;
    logic wd_hit;
    logic raw_hzd;
    logic waw_hzd;

    assign in_reset = (rst == RstEnable);

    hazard_scoreboard u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .set_en_i   (issue_o & id_wreg_i),
        .set_addr_i (id_wd_i),
        .clr_en_i   (wb_wreg_i),
        .clr_addr_i (wb_wd_i),
        .rd1_addr_i (id_reg1_addr_i),
        .rd2_addr_i (id_reg2_addr_i),
        .wd_addr_i  (id_wd_i),
        .rd1_hit_o  (rd1_hit),
        .rd2_hit_o  (rd2_hit),
        .wd_hit_o   (wd_hit),
        .pending_o  (pending_o)
    );

    // Hazard detection, stall priority and issue decision.
    always_comb begin
        raw_hzd = id_valid_i & ((id_reg1_read_i & rd1_hit) | (id_reg2_read_i & rd2_hit));
        waw_hzd = id_valid_i & id_wreg_i & wd_hit;
        stall_o = StallNone;
        if (in_reset) begin
            stall_o = StallNone;
        end else if (state_q == ST_MC_BUSY) begin
            stall_o = StallMc;
        end else if (raw_hzd || waw_hzd) begin
            stall_o = StallHzd;
        end
        // Flush only suppresses issue; it never touches the stall vector.
        issue_o = ~in_reset & id_valid_i & ~flush_i & (stall_o == StallNone);
    end

    // Multi-cycle FSM next state and occupancy counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (issue_o && id_mc_i) begin
                    state_d = ST_MC_BUSY;
                    cnt_d   = McLoad;
                end
            end
            ST_MC_BUSY: begin
                // Leaving on count 1 gives MC_LAT-1 busy cycles after issue.
                if (cnt_q <= McCntW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - McCntW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Saturating count of stalled cycles.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if ((stall_o != StallNone) && (stall_cnt_q != StallCntMax)) begin
            stall_cnt_d = stall_cnt_q + StallCntW'(1);
        end
    end

    // State registers; reset aborts any multi-cycle op immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign busy_o      = (state_q == ST_MC_BUSY);
    assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl with a queue-based scoreboard.
// Stimulus pushes the hand-computed response for each cycle; a monitor
// pops and compares at the falling edge of the same cycle.
module tb_hazard_ctrl;

    logic        clk;
    logic        rst;
    logic        id_valid_i;
    logic        id_reg1_read_i;
    logic        id_reg2_read_i;
    logic [4:0]  id_reg1_addr_i;
    logic [4:0]  id_reg2_addr_i;
    logic        id_wreg_i;
    logic [4:0]  id_wd_i;
    logic        id_mc_i;
    logic        wb_wreg_i;
    logic [4:0]  wb_wd_i;
    logic        flush_i;
    logic [5:0]  stall_o;
    logic        issue_o;
    logic        busy_o;
    logic [31:0] pending_o;
    logic [15:0] stall_cnt_o;

    typedef struct {
        int          idx;
        logic [5:0]  stall;
        logic        issue;
        logic        busy;
        logic [31:0] pend;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   vec_no = 0;
    int   cnt_model = 0;

    hazard_ctrl #(.MC_LAT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid_i     (id_valid_i),
        .id_reg1_read_i (id_reg1_read_i),
        .id_reg2_read_i (id_reg2_read_i),
        .id_reg1_addr_i (id_reg1_addr_i),
        .id_reg2_addr_i (id_reg2_addr_i),
        .id_wreg_i      (id_wreg_i),
        .id_wd_i        (id_wd_i),
        .id_mc_i        (id_mc_i),
        .wb_wreg_i      (wb_wreg_i),
        .wb_wd_i        (wb_wd_i),
        .flush_i        (flush_i),
        .stall_o        (stall_o),
        .issue_o        (issue_o),
        .busy_o         (busy_o),
        .pending_o      (pending_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One cycle of stimulus: drive just after the rising edge, queue the expectation.
    task automatic step(input logic r, input logic vld,
                        input logic r1, input logic [4:0] a1,
                        input logic r2, input logic [4:0] a2,
                        input logic wr, input logic [4:0] wd, input logic mc,
                        input logic wbw, input logic [4:0] wbd, input logic fl,
                        input logic [5:0] e_stall, input logic e_issue,
                        input logic e_busy, input logic [31:0] e_pend);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_valid_i = vld;
        id_reg1_read_i = r1; id_reg1_addr_i = a1;
        id_reg2_read_i = r2; id_reg2_addr_i = a2;
        id_wreg_i = wr; id_wd_i = wd; id_mc_i = mc;
        wb_wreg_i = wbw; wb_wd_i = wbd; flush_i = fl;
        if (r) cnt_model = 0;
        e.idx = vec_no; e.stall = e_stall; e.issue = e_issue;
        e.busy = e_busy; e.pend = e_pend; e.cnt = 16'(cnt_model);
        exp_q.push_back(e);
        if (!r && e_stall != 6'b0) cnt_model++;
        vec_no++;
    endtask

    // Monitor: compare every queued expectation mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (stall_o !== e.stall) begin
                errors++;
                $display("FAIL v%0d stall_o got %b want %b", e.idx, stall_o, e.stall);
            end
            checks++;
            if (issue_o !== e.issue) begin
                errors++;
                $display("FAIL v%0d issue_o got %b want %b", e.idx, issue_o, e.issue);
            end
            checks++;
            if (busy_o !== e.busy) begin
                errors++;
                $display("FAIL v%0d busy_o got %b want %b", e.idx, busy_o, e.busy);
            end
            checks++;
            if (pending_o !== e.pend) begin
                errors++;
                $display("FAIL v%0d pending_o got %h want %h", e.idx, pending_o, e.pend);
            end
            checks++;
            if (stall_cnt_o !== e.cnt) begin
                errors++;
                $display("FAIL v%0d stall_cnt_o got %0d want %0d", e.idx, stall_cnt_o, e.cnt);
            end
        end
    end

    localparam logic [5:0] S0 = 6'b000000;
    localparam logic [5:0] SH = 6'b000111;
    localparam logic [5:0] SM = 6'b001111;

    initial begin
        rst = 1'b1; id_valid_i = 1'b0;
        id_reg1_read_i = 1'b0; id_reg1_addr_i = 5'd0;
        id_reg2_read_i = 1'b0; id_reg2_addr_i = 5'd0;
        id_wreg_i = 1'b0; id_wd_i = 5'd0; id_mc_i = 1'b0;
        wb_wreg_i = 1'b0; wb_wd_i = 5'd0; flush_i = 1'b0;

        //   rst vld r1 a1 r2 a2 wr wd mc wbw wbd fl | stall iss busy pending
        // Reset held with a valid writer in ID: nothing issues, all zero.
        step(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,   S0, 0, 0, 32'h0);
        step(1, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,   S0, 0, 0, 32'h0);
        // Issue write r5.
        step(0, 1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        // Read r5 with no WB: RAW stall until WB r5 arrives.
        step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   SH, 0, 0, 32'h20);
        step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0,   SH, 0, 0, 32'h20);
        step(0, 1, 1, 5, 0, 0, 0, 0, 0, 1, 5, 0,   S0, 1, 0, 32'h20);
        // Write r9, then read r9 in the same cycle WB writes it: bypass.
        step(0, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 1, 1, 9, 0, 0, 0, 0, 0, 1, 9, 0,   S0, 1, 0, 32'h200);
        // Write r7, then rewrite r7 on the edge WB clears it: set wins.
        step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 1, 0, 0, 0, 0, 1, 7, 0, 1, 7, 0,   S0, 1, 0, 32'h80);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h80);
        // WAW on r7 without WB stalls.
        step(0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0,   SH, 0, 0, 32'h80);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0,   S0, 0, 0, 32'h80);
        // Write r0 never marks pending; reading r0 never stalls.
        step(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        // Multi-cycle op writing r3: exactly 3 busy cycles, clean ID cannot issue.
        step(0, 1, 0, 0, 0, 0, 1, 3, 1, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   SM, 0, 1, 32'h8);
        step(0, 1, 0, 0, 0, 0, 1, 10, 0, 0, 0, 0,  SM, 0, 1, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   SM, 0, 1, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h8);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0,   S0, 0, 0, 32'h8);
        // Multi-cycle write r5, reset during its second busy cycle.
        step(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   SM, 0, 1, 32'h20);
        step(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h0);
        // Flush with a clean multi-cycle writer: no issue, no state change.
        step(0, 1, 0, 0, 0, 0, 1, 6, 1, 0, 0, 1,   S0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h0);
        // Flush with r4 pending: scoreboard unchanged; port-2 RAW also stalls.
        step(0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0,   S0, 1, 0, 32'h0);
        step(0, 1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1,   SH, 0, 0, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,   S0, 0, 0, 32'h10);
        step(0, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0,   SH, 0, 0, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0,   S0, 0, 0, 32'h10);
        step(0, 1, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0,   S0, 1, 0, 32'h0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain queue left %0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
